// File: rtl/video_capture_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : video_capture_if
// Brief    : Wishbone classic write-master bundle used by the video grabber.
//            The master modport drives the request side; the slave modport
//            returns the acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
interface video_capture_if;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    output adr, dat_ms, cyc, stb, we, sel, cti, bte,
    input  ack
  );

  modport slave (
    input  adr, dat_ms, cyc, stb, we, sel, cti, bte,
    output ack
  );
endinterface
`default_nettype wire

// File: rtl/video_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : video_capture
// Brief    : Grabs the active area of an HS/VS/BLANK/RGB stream and writes
//            one 32-bit word per pixel into the framebuffer over Wishbone.
//            Pixels cross from pixel_clk to wshb_clk through a gray-coded,
//            first-word-fall-through asynchronous FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module video_capture #(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter int          FIFO_DW  = 8,
  parameter logic [31:0] BASE_ADR = 32'h0
) (
  input  wire              pixel_clk,
  input  wire              pixel_rst,
  input  wire              wshb_clk,
  input  wire              wshb_rst,
  input  wire              vid_hs,
  input  wire              vid_vs,
  input  wire              vid_blank,
  input  wire  [23:0]      vid_rgb,
  video_capture_if.master  wshb,
  output logic             frame_done,
  output logic             overflow
);

  localparam int              c_TOTAL    = HDISP * VDISP;
  localparam int              c_CW       = $clog2(c_TOTAL + 1);
  localparam int              c_DEPTH    = 1 << FIFO_DW;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_TOTAL - 1);
  localparam logic [31:0]     c_ADR_LAST = BASE_ADR + 32'(4 * (c_TOTAL - 1));

  typedef enum logic [1:0] {
    PX_WAIT_VS  = 2'd0,
    PX_WAIT_ACT = 2'd1,
    PX_CAPTURE  = 2'd2
  } px_state_t;

  typedef enum logic [0:0] {
    BUS_IDLE  = 1'b0,
    BUS_WRITE = 1'b1
  } bus_state_t;

  // Either side resetting empties the FIFO, so both pointer sets restart together.
  logic w_fifo_rst;
  assign w_fifo_rst = pixel_rst | wshb_rst;

  // Line sync carries no information the grabber needs; blank already frames each line.
  logic w_unused_hs;
  assign w_unused_hs = vid_hs;

  // ---------------------------------------------------------------- pixel side
  logic            r_vs_q;
  logic            r_blank_q;
  logic            r_vs_fall;
  logic [23:0]     r_rgb_q;
  px_state_t       r_px_state;
  px_state_t       w_px_next;
  logic            w_accept;
  logic            w_last;
  logic            w_push;
  logic [c_CW-1:0] r_cnt;
  logic            r_pending_sof;

  logic [FIFO_DW:0] r_wbin, r_wgray, r_rgray_s1, r_rgray_s2, w_wbin_next;
  logic             w_wfull;
  logic [24:0]      r_mem [c_DEPTH];

  // Register the video inputs once and detect the falling edge of frame sync.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_vs_q    <= 1'b0;
      r_blank_q <= 1'b0;
      r_vs_fall <= 1'b0;
      r_rgb_q   <= 24'h0;
    end else begin
      r_vs_q    <= vid_vs;
      r_blank_q <= vid_blank;
      r_vs_fall <= r_vs_q & ~vid_vs;
      r_rgb_q   <= vid_rgb;
    end
  end

  // Pixel FSM: arm on frame sync, then take exactly one frame's worth of active pixels.
  always_comb begin
    w_px_next = r_px_state;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    case (r_px_state)
      PX_WAIT_VS: begin
        if (r_vs_fall) w_px_next = PX_WAIT_ACT;
      end
      PX_WAIT_ACT, PX_CAPTURE: begin
        if (r_vs_fall) begin
          w_px_next = PX_WAIT_ACT;
        end else if (r_blank_q) begin
          w_accept = 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            w_last    = 1'b1;
            w_px_next = PX_WAIT_VS;
          end else begin
            w_px_next = PX_CAPTURE;
          end
        end
      end
      default: w_px_next = PX_WAIT_VS;
    endcase
  end

  assign w_push = w_accept & ~w_wfull;

  // Pixel FSM state register.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) r_px_state <= PX_WAIT_VS;
    else           r_px_state <= w_px_next;
  end

  // Frame counter, start-of-frame marker, completion pulse and sticky drop flag.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_cnt         <= '0;
      r_pending_sof <= 1'b1;
      frame_done    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      frame_done <= w_last;
      if (r_px_state == PX_WAIT_VS || r_vs_fall) r_cnt <= '0;
      else if (w_accept)                         r_cnt <= r_cnt + c_CW'(1);
      if (r_vs_fall)   r_pending_sof <= 1'b1;
      else if (w_push) r_pending_sof <= 1'b0;
      if (w_accept && w_wfull) overflow <= 1'b1;
    end
  end

  assign w_wbin_next = r_wbin + (FIFO_DW + 1)'(1);
  assign w_wfull     = (r_wgray == {~r_rgray_s2[FIFO_DW:FIFO_DW-1], r_rgray_s2[FIFO_DW-2:0]});

  // FIFO write pointer plus synchronizer for the read pointer.
  always_ff @(posedge pixel_clk or posedge w_fifo_rst) begin
    if (w_fifo_rst) begin
      r_wbin     <= '0;
      r_wgray    <= '0;
      r_rgray_s1 <= '0;
      r_rgray_s2 <= '0;
    end else begin
      if (w_push) begin
        r_wbin  <= w_wbin_next;
        r_wgray <= w_wbin_next ^ (w_wbin_next >> 1);
      end
      r_rgray_s1 <= r_rgray;
      r_rgray_s2 <= r_rgray_s1;
    end
  end

  // FIFO storage; each entry is {sof, rgb}.
  always_ff @(posedge pixel_clk) begin
    if (w_push) r_mem[r_wbin[FIFO_DW-1:0]] <= {r_pending_sof, r_rgb_q};
  end

  // ------------------------------------------------------------------ bus side
  logic [FIFO_DW:0] r_rbin, r_rgray, r_wgray_s1, r_wgray_s2, w_rbin_next;
  logic             w_rempty;
  logic [24:0]      w_rdata;
  bus_state_t       r_bus_state;
  bus_state_t       w_bus_next;
  logic             w_pop;
  logic [31:0]      r_adr;
  logic [31:0]      r_adr_next;
  logic [31:0]      r_dat;

  assign w_rbin_next = r_rbin + (FIFO_DW + 1)'(1);
  assign w_rempty    = (r_rgray == r_wgray_s2);
  assign w_rdata     = r_mem[r_rbin[FIFO_DW-1:0]];

  // FIFO read pointer plus synchronizer for the write pointer.
  always_ff @(posedge wshb_clk or posedge w_fifo_rst) begin
    if (w_fifo_rst) begin
      r_rbin     <= '0;
      r_rgray    <= '0;
      r_wgray_s1 <= '0;
      r_wgray_s2 <= '0;
    end else begin
      if (w_pop) begin
        r_rbin  <= w_rbin_next;
        r_rgray <= w_rbin_next ^ (w_rbin_next >> 1);
      end
      r_wgray_s1 <= r_wgray;
      r_wgray_s2 <= r_wgray_s1;
    end
  end

  // Bus FSM: pop one word while idle, then hold a single write until acknowledged.
  always_comb begin
    w_bus_next = r_bus_state;
    w_pop      = 1'b0;
    case (r_bus_state)
      BUS_IDLE: begin
        if (!w_rempty) begin
          w_pop      = 1'b1;
          w_bus_next = BUS_WRITE;
        end
      end
      BUS_WRITE: begin
        if (wshb.ack) w_bus_next = BUS_IDLE;
      end
      default: w_bus_next = BUS_IDLE;
    endcase
  end

  // Bus FSM state register; reset drops cyc immediately.
  always_ff @(posedge wshb_clk or posedge wshb_rst) begin
    if (wshb_rst) r_bus_state <= BUS_IDLE;
    else          r_bus_state <= w_bus_next;
  end

  // Address/data registers; a start-of-frame word resynchronizes the address to the base.
  always_ff @(posedge wshb_clk or posedge wshb_rst) begin
    if (wshb_rst) begin
      r_adr      <= BASE_ADR;
      r_adr_next <= BASE_ADR;
      r_dat      <= 32'h0;
    end else begin
      if (w_pop) begin
        r_dat <= {8'h00, w_rdata[23:0]};
        r_adr <= w_rdata[24] ? BASE_ADR : r_adr_next;
      end
      if (r_bus_state == BUS_WRITE && wshb.ack) begin
        r_adr_next <= (r_adr == c_ADR_LAST) ? BASE_ADR : r_adr + 32'd4;
      end
    end
  end

  assign wshb.cyc    = (r_bus_state == BUS_WRITE);
  assign wshb.stb    = (r_bus_state == BUS_WRITE);
  assign wshb.we     = 1'b1;
  assign wshb.sel    = 4'b1111;
  assign wshb.cti    = 3'b000;
  assign wshb.bte    = 2'b00;
  assign wshb.adr    = r_adr;
  assign wshb.dat_ms = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_video_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_video_capture
// Brief    : Random-pixel bench for video_capture. Frames are generated with
//            random RGB and the expected framebuffer writes are listed as
//            (address, data) pairs from the frame's pixel order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_capture;
  localparam int          HDISP   = 4;
  localparam int          VDISP   = 2;
  localparam int          TOTAL   = HDISP * VDISP;
  localparam int          FIFO_DW = 2;
  localparam int          DEPTH   = 1 << FIFO_DW;
  localparam logic [31:0] BASE    = 32'h100;

  logic        pixel_clk = 1'b0;
  logic        wshb_clk  = 1'b0;
  logic        pixel_rst = 1'b1;
  logic        wshb_rst  = 1'b1;
  logic        vid_hs    = 1'b1;
  logic        vid_vs    = 1'b1;
  logic        vid_blank = 1'b0;
  logic [23:0] vid_rgb   = 24'h0;
  logic        frame_done;
  logic        overflow;

  video_capture_if wshb ();

  video_capture #(
    .HDISP(HDISP), .VDISP(VDISP), .FIFO_DW(FIFO_DW), .BASE_ADR(BASE)
  ) dut (
    .pixel_clk (pixel_clk),
    .pixel_rst (pixel_rst),
    .wshb_clk  (wshb_clk),
    .wshb_rst  (wshb_rst),
    .vid_hs    (vid_hs),
    .vid_vs    (vid_vs),
    .vid_blank (vid_blank),
    .vid_rgb   (vid_rgb),
    .wshb      (wshb),
    .frame_done(frame_done),
    .overflow  (overflow)
  );

  always #10 pixel_clk = ~pixel_clk;
  always #2  wshb_clk  = ~wshb_clk;

  int          n_vec  = 0;
  int          n_err  = 0;
  int          fd_cnt = 0;
  int          exp_fd = 0;
  bit          ack_en = 1'b0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  logic [23:0] frame_px[$];

  // Slave: acknowledge one cycle after strobe and log each accepted write.
  initial begin
    wshb.ack = 1'b0;
    forever begin
      @(negedge wshb_clk);
      if (wshb.cyc === 1'b1 && wshb.stb === 1'b1 && wshb.ack === 1'b0 && ack_en) begin
        wshb.ack = 1'b1;
        obs_q.push_back({wshb.adr, wshb.dat_ms});
      end else begin
        wshb.ack = 1'b0;
      end
    end
  end

  // Count frame completion pulses.
  initial forever begin
    @(negedge pixel_clk);
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic drive(input logic hs, input logic vs, input logic blank, input logic [23:0] rgb);
    @(negedge pixel_clk);
    vid_hs = hs; vid_vs = vs; vid_blank = blank; vid_rgb = rgb;
  endtask

  // One frame of video; only the first npix active pixels are sent. The model:
  // after a frame sync every active pixel lands at BASE + 4*index, and a full
  // frame produces one completion pulse; without a sync nothing is captured.
  task automatic send_frame(input int npix, input bit vsync, input bit gaps, input bit expect_wr);
    int          sent = 0;
    logic [23:0] px;
    frame_px.delete();
    if (vsync) begin
      repeat (2) drive(1'b1, 1'b1, 1'b0, 24'($urandom));
      repeat (2) drive(1'b1, 1'b0, 1'b0, 24'($urandom));
      repeat (2) drive(1'b1, 1'b1, 1'b0, 24'($urandom));
    end
    for (int y = 0; y < VDISP; y++) begin
      drive(1'b0, 1'b1, 1'b0, 24'($urandom));
      repeat (2) drive(1'b1, 1'b1, 1'b0, 24'($urandom));
      for (int x = 0; x < HDISP && sent < npix; x++) begin
        if (gaps && $urandom_range(0, 1) == 1)
          repeat ($urandom_range(1, 2)) drive(1'b1, 1'b1, 1'b0, 24'($urandom));
        px = 24'($urandom);
        drive(1'b1, 1'b1, 1'b1, px);
        frame_px.push_back(px);
        sent++;
      end
      repeat (3) drive(1'b1, 1'b1, 1'b0, 24'($urandom));
    end
    if (vsync && expect_wr)
      for (int i = 0; i < sent; i++) exp_q.push_back({BASE + 32'(4 * i), 8'h00, frame_px[i]});
    if (vsync && sent == TOTAL) exp_fd++;
  endtask

  // Wait (bounded) for the expected writes, then a little longer to expose extras.
  task automatic drain();
    int guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 3000) begin
      @(negedge wshb_clk);
      guard++;
    end
    repeat (40) @(negedge wshb_clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge pixel_clk);
    n_vec++; if (wshb.cyc !== 1'b0)    begin n_err++; $display("FAIL reset cyc: got %b want 0", wshb.cyc); end
    n_vec++; if (wshb.stb !== 1'b0)    begin n_err++; $display("FAIL reset stb: got %b want 0", wshb.stb); end
    n_vec++; if (wshb.adr !== BASE)    begin n_err++; $display("FAIL reset adr: got %h want %h", wshb.adr, BASE); end
    n_vec++; if (wshb.dat_ms !== 32'h0) begin n_err++; $display("FAIL reset dat: got %h want 0", wshb.dat_ms); end
    n_vec++; if (wshb.we !== 1'b1 || wshb.sel !== 4'hF || wshb.cti !== 3'h0 || wshb.bte !== 2'h0) begin
      n_err++; $display("FAIL reset consts: got we=%b sel=%h cti=%h bte=%h want 1 f 0 0", wshb.we, wshb.sel, wshb.cti, wshb.bte);
    end
    n_vec++; if (frame_done !== 1'b0)  begin n_err++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
    n_vec++; if (overflow !== 1'b0)    begin n_err++; $display("FAIL reset overflow: got %b want 0", overflow); end
    @(negedge pixel_clk);
    pixel_rst = 1'b0;
    wshb_rst  = 1'b0;
    ack_en    = 1'b1;
    repeat (4) @(negedge pixel_clk);
  endtask

  task automatic test_two_frames();
    send_frame(TOTAL, 1'b1, 1'b0, 1'b1);
    send_frame(TOTAL, 1'b1, 1'b0, 1'b1);
    drain();
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL two_frames count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL two_frames write %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (fd_cnt != exp_fd) begin n_err++; $display("FAIL two_frames frame_done: got %0d want %0d", fd_cnt, exp_fd); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_truncated();
    send_frame(5, 1'b1, 1'b0, 1'b1);
    send_frame(TOTAL, 1'b1, 1'b0, 1'b1);
    drain();
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL truncated count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL truncated write %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (fd_cnt != exp_fd) begin n_err++; $display("FAIL truncated frame_done: got %0d want %0d", fd_cnt, exp_fd); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_blank_gaps();
    send_frame(TOTAL, 1'b1, 1'b1, 1'b1);
    send_frame(TOTAL, 1'b1, 1'b1, 1'b1);
    drain();
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL blank_gaps count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL blank_gaps write %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (fd_cnt != exp_fd) begin n_err++; $display("FAIL blank_gaps frame_done: got %0d want %0d", fd_cnt, exp_fd); end
    obs_q.delete(); exp_q.delete();
  endtask

  // Stalled slave: one word sits on the bus, DEPTH more fit in the FIFO, the rest drop.
  task automatic test_overflow();
    ack_en = 1'b0;
    send_frame(TOTAL, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i <= DEPTH; i++) exp_q.push_back({BASE + 32'(4 * i), 8'h00, frame_px[i]});
    repeat (170) @(negedge wshb_clk);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow flag: got %b want 1", overflow); end
    n_vec++; if (wshb.cyc !== 1'b1 || wshb.adr !== BASE || wshb.dat_ms !== {8'h00, frame_px[0]}) begin
      n_err++; $display("FAIL overflow stall: got cyc=%b adr=%h dat=%h want 1 %h %h", wshb.cyc, wshb.adr, wshb.dat_ms, BASE, {8'h00, frame_px[0]});
    end
    n_vec++; if (fd_cnt != exp_fd) begin n_err++; $display("FAIL overflow frame_done: got %0d want %0d", fd_cnt, exp_fd); end
    ack_en = 1'b1;
    drain();
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL overflow count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL overflow write %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  // Pixel reset mid-frame, then a stream with no frame sync, then a proper frame.
  task automatic test_pixel_rst();
    send_frame(5, 1'b1, 1'b0, 1'b1);
    drain();
    @(negedge pixel_clk); pixel_rst = 1'b1;
    @(negedge pixel_clk); pixel_rst = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pixel_rst overflow: got %b want 0", overflow); end
    send_frame(TOTAL, 1'b0, 1'b0, 1'b1);
    send_frame(TOTAL, 1'b1, 1'b0, 1'b1);
    drain();
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL pixel_rst count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL pixel_rst write %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (fd_cnt != exp_fd) begin n_err++; $display("FAIL pixel_rst frame_done: got %0d want %0d", fd_cnt, exp_fd); end
    obs_q.delete(); exp_q.delete();
  endtask

  // Bus reset while a write is pending; the frame in flight is lost.
  task automatic test_wshb_rst();
    ack_en = 1'b0;
    fork
      send_frame(TOTAL, 1'b1, 1'b0, 1'b0);
      begin
        int guard = 0;
        while (wshb.cyc !== 1'b1 && guard < 500) begin
          @(negedge wshb_clk);
          guard++;
        end
        n_vec++; if (wshb.cyc !== 1'b1) begin n_err++; $display("FAIL wshb_rst start: got cyc=%b want 1", wshb.cyc); end
        @(negedge wshb_clk);
        #0.5 wshb_rst = 1'b1;
        #0.2;
        n_vec++; if (wshb.cyc !== 1'b0 || wshb.stb !== 1'b0) begin
          n_err++; $display("FAIL wshb_rst drop: got cyc=%b stb=%b want 0 0", wshb.cyc, wshb.stb);
        end
        n_vec++; if (wshb.adr !== BASE) begin n_err++; $display("FAIL wshb_rst adr: got %h want %h", wshb.adr, BASE); end
      end
    join
    repeat (4) @(negedge wshb_clk);
    wshb_rst = 1'b0;
    ack_en   = 1'b1;
    send_frame(TOTAL, 1'b1, 1'b0, 1'b1);
    drain();
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL wshb_rst count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wshb_rst write %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (fd_cnt != exp_fd) begin n_err++; $display("FAIL wshb_rst frame_done: got %0d want %0d", fd_cnt, exp_fd); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_truncated();
    test_blank_gaps();
    test_overflow();
    test_pixel_rst();
    test_wshb_rst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
